// File: rtl/gb_pkg.sv
// Shared ghostbus definitions: initiator state encoding and the default bus widths
// also used by the ghostbus decoder generator.
package gb_pkg;

  localparam int unsigned GB_AW = 24;
  localparam int unsigned GB_DW = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_DRAIN = 2'd3
  } gb_state_e;

endpackage

// File: rtl/gb_rd_fifo.sv
// First-word-fall-through synchronous FIFO holding returned read beats (data + last tag).
// The occupancy count feeds the initiator's read-issue credit check.
module gb_rd_fifo #(
  parameter int unsigned W     = 33,
  parameter int unsigned DEPTH = 3
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic [W-1:0]                 push_data,
  input  logic                         pop,
  output logic [W-1:0]                 pop_data,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    do_push  = push && (count_q != CW'(DEPTH));
    do_pop   = pop && (count_q != '0);
    wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = do_pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  assign pop_data = mem_q[rd_ptr_q];
  assign empty    = (count_q == '0);
  assign count    = count_q;

endmodule

// File: rtl/gb_host_initiator.sv
// Ghostbus initiator: turns read/write burst commands into registered bus strobes,
// streaming write data in and buffering fixed-latency read returns out.
module gb_host_initiator
  import gb_pkg::*;
#(
  parameter int unsigned AW         = GB_AW,
  parameter int unsigned DW         = GB_DW,
  parameter int unsigned RD_LAT     = 1,
  parameter int unsigned LW         = 8,
  parameter int unsigned FIFO_DEPTH = RD_LAT + 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_write,
  input  logic [AW-1:0] req_addr,
  input  logic [LW-1:0] req_len,
  input  logic          wd_valid,
  output logic          wd_ready,
  input  logic [DW-1:0] wd_data,
  output logic          rd_valid,
  input  logic          rd_ready,
  output logic [DW-1:0] rd_data,
  output logic          rd_last,
  output logic          busy,
  output logic [AW-1:0] gb_addr,
  output logic [DW-1:0] gb_dout,
  output logic          gb_we,
  output logic          gb_re,
  input  logic [DW-1:0] gb_din
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

  gb_state_e         state_q, state_d;
  logic              init_q;
  logic [AW-1:0]     base_q, base_d;
  logic [LW-1:0]     remain_q, remain_d;
  logic [LW-1:0]     beat_q, beat_d;
  logic [AW-1:0]     gb_addr_q, gb_addr_d;
  logic [DW-1:0]     gb_dout_q, gb_dout_d;
  logic              gb_we_q, gb_we_d;
  logic              gb_re_q, gb_re_d;
  logic              gb_last_q, gb_last_d;
  logic [RD_LAT-1:0] pipe_v_q, pipe_v_d;
  logic [RD_LAT-1:0] pipe_last_q, pipe_last_d;
  logic [CW-1:0]     out_q, out_d;

  logic              req_hs, wd_hs, final_beat, issue, credit_ok;
  logic              fifo_push, fifo_pop, fifo_empty;
  logic [CW-1:0]     fifo_count;
  logic [CW:0]       credit_used;
  logic [DW:0]       fifo_rdata;
  logic [AW-1:0]     beat_addr;

  assign req_hs     = req_valid && req_ready;
  assign wd_hs      = wd_valid && wd_ready;
  assign final_beat = (beat_q == remain_q);
  assign beat_addr  = base_q + AW'(beat_q);
  assign fifo_push  = pipe_v_q[RD_LAT-1];
  assign fifo_pop   = rd_valid && rd_ready;

  // A pop in the same cycle frees a slot, so it is credited immediately to keep one beat/cycle.
  assign credit_used = {1'b0, out_q} + {1'b0, fifo_count} - {{CW{1'b0}}, fifo_pop};
  assign credit_ok   = credit_used < (CW+1)'(FIFO_DEPTH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (req_hs) state_d = req_write ? ST_WRITE : ST_READ;
      ST_WRITE: if (wd_hs && final_beat) state_d = ST_IDLE;
      ST_READ:  if (issue && final_beat) state_d = ST_DRAIN;
      ST_DRAIN: if (fifo_pop && rd_last) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready = 1'b0;
    wd_ready  = 1'b0;
    busy      = 1'b1;
    issue     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        req_ready = init_q;
        busy      = 1'b0;
      end
      ST_WRITE: wd_ready = 1'b1;
      ST_READ:  issue    = credit_ok;
      default:  ;
    endcase
  end

  always_comb begin
    base_d      = base_q;
    remain_d    = remain_q;
    beat_d      = beat_q;
    gb_addr_d   = gb_addr_q;
    gb_dout_d   = gb_dout_q;
    gb_we_d     = 1'b0;
    gb_re_d     = 1'b0;
    gb_last_d   = 1'b0;
    if (req_hs) begin
      base_d   = req_addr;
      remain_d = req_len;
      beat_d   = '0;
    end
    if (wd_hs) begin
      gb_we_d   = 1'b1;
      gb_addr_d = beat_addr;
      gb_dout_d = wd_data;
      beat_d    = beat_q + LW'(1);
    end
    if (issue) begin
      gb_re_d   = 1'b1;
      gb_addr_d = beat_addr;
      gb_last_d = final_beat;
      beat_d    = beat_q + LW'(1);
    end
    pipe_v_d[0]    = gb_re_q;
    pipe_last_d[0] = gb_last_q;
    for (int unsigned i = 1; i < RD_LAT; i++) begin
      pipe_v_d[i]    = pipe_v_q[i-1];
      pipe_last_d[i] = pipe_last_q[i-1];
    end
    out_d = out_q + CW'(issue) - CW'(fifo_push);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init_q      <= 1'b0;
      base_q      <= '0;
      remain_q    <= '0;
      beat_q      <= '0;
      gb_addr_q   <= '0;
      gb_dout_q   <= '0;
      gb_we_q     <= 1'b0;
      gb_re_q     <= 1'b0;
      gb_last_q   <= 1'b0;
      pipe_v_q    <= '0;
      pipe_last_q <= '0;
      out_q       <= '0;
    end else begin
      init_q      <= 1'b1;
      base_q      <= base_d;
      remain_q    <= remain_d;
      beat_q      <= beat_d;
      gb_addr_q   <= gb_addr_d;
      gb_dout_q   <= gb_dout_d;
      gb_we_q     <= gb_we_d;
      gb_re_q     <= gb_re_d;
      gb_last_q   <= gb_last_d;
      pipe_v_q    <= pipe_v_d;
      pipe_last_q <= pipe_last_d;
      out_q       <= out_d;
    end
  end

  gb_rd_fifo #(
    .W     (DW + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_rd_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fifo_push),
    .push_data ({pipe_last_q[RD_LAT-1], gb_din}),
    .pop       (fifo_pop),
    .pop_data  (fifo_rdata),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign rd_valid = !fifo_empty;
  assign rd_data  = rd_valid ? fifo_rdata[DW-1:0] : '0;
  assign rd_last  = rd_valid && fifo_rdata[DW];
  assign gb_addr  = gb_addr_q;
  assign gb_dout  = gb_dout_q;
  assign gb_we    = gb_we_q;
  assign gb_re    = gb_re_q;

endmodule

// File: tb/tb_gb_host_initiator.sv
// Scoreboard bench for gb_host_initiator: two instances (RD_LAT=1 and RD_LAT=3) share stimulus,
// each with its own ghostbus read model and monitor.
module tb_gb_host_initiator;
  import gb_pkg::*;

  localparam int unsigned AW = GB_AW;
  localparam int unsigned DW = GB_DW;
  localparam int unsigned LW = 8;

  typedef struct packed {
    logic          we;
    logic          last;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } bus_t;

  typedef struct packed {
    logic          last;
    logic [DW-1:0] data;
  } beat_t;

  logic          clk       = 1'b0;
  logic          rst_n     = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_write = 1'b0;
  logic [AW-1:0] req_addr  = '0;
  logic [LW-1:0] req_len   = '0;
  logic          wd_valid  = 1'b0;
  logic [DW-1:0] wd_data   = '0;
  logic          rd_ready  = 1'b0;

  logic          req_ready_w [2];
  logic          wd_ready_w  [2];
  logic          rd_valid_w  [2];
  logic          rd_last_w   [2];
  logic          busy_w      [2];
  logic          gb_we_w     [2];
  logic          gb_re_w     [2];
  logic [DW-1:0] rd_data_w   [2];
  logic [DW-1:0] gb_dout_w   [2];
  logic [DW-1:0] gb_din_w    [2];
  logic [AW-1:0] gb_addr_w   [2];

  bus_t          exp_bus [2][$];
  beat_t         exp_rd  [2][$];
  logic [AW-1:0] re_log  [2][$];
  int unsigned   re_cnt  [2];
  int unsigned   n_checks = 0;
  int unsigned   n_pass   = 0;

  always #5 clk = ~clk;

  task automatic check(input string name, input int inst, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s (dut%0d): got 0x%0h, expected 0x%0h", name, inst, act, exp);
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int unsigned LAT = (g == 0) ? 1 : 3;

    logic [DW-1:0] bus_pipe [LAT];
    logic          busy_chk = 1'b0;
    bus_t          eb;
    beat_t         er;

    gb_host_initiator #(
      .AW         (AW),
      .DW         (DW),
      .RD_LAT     (LAT),
      .LW         (LW),
      .FIFO_DEPTH (LAT + 2)
    ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready_w[g]),
      .req_write (req_write),
      .req_addr  (req_addr),
      .req_len   (req_len),
      .wd_valid  (wd_valid),
      .wd_ready  (wd_ready_w[g]),
      .wd_data   (wd_data),
      .rd_valid  (rd_valid_w[g]),
      .rd_ready  (rd_ready),
      .rd_data   (rd_data_w[g]),
      .rd_last   (rd_last_w[g]),
      .busy      (busy_w[g]),
      .gb_addr   (gb_addr_w[g]),
      .gb_dout   (gb_dout_w[g]),
      .gb_we     (gb_we_w[g]),
      .gb_re     (gb_re_w[g]),
      .gb_din    (gb_din_w[g])
    );

    // Peripheral model: read data is address ^ 0xA5A5, valid LAT cycles after gb_re.
    always @(posedge clk) begin
      bus_pipe[0] <= gb_re_w[g] ? (DW'(gb_addr_w[g]) ^ 32'h0000_A5A5) : 32'hBAD0_BAD0;
      for (int i = 1; i < LAT; i++) bus_pipe[i] <= bus_pipe[i-1];
    end
    assign gb_din_w[g] = bus_pipe[LAT-1];

    always @(negedge clk) begin
      if (!rst_n) begin
        busy_chk = 1'b0;
      end else begin
        if (busy_chk) begin
          check("busy_after_last", g, busy_w[g], 0);
          busy_chk = 1'b0;
        end
        if (gb_we_w[g] || gb_re_w[g]) begin
          check("we_re_exclusive", g, gb_we_w[g] & gb_re_w[g], 0);
          if (gb_re_w[g]) begin
            re_cnt[g]++;
            re_log[g].push_back(gb_addr_w[g]);
          end
          check("bus_strobe_expected", g, exp_bus[g].size() != 0, 1);
          if (exp_bus[g].size() != 0) begin
            eb = exp_bus[g].pop_front();
            check("gb_we", g, gb_we_w[g], eb.we);
            check("gb_addr", g, gb_addr_w[g], eb.addr);
            if (eb.we) check("gb_dout", g, gb_dout_w[g], eb.data);
            if (eb.we && eb.last) check("req_ready_after_write", g, req_ready_w[g], 1);
          end
        end
        if (rd_valid_w[g] && rd_ready) begin
          check("rd_beat_expected", g, exp_rd[g].size() != 0, 1);
          if (exp_rd[g].size() != 0) begin
            er = exp_rd[g].pop_front();
            check("rd_data", g, rd_data_w[g], er.data);
            check("rd_last", g, rd_last_w[g], er.last);
            if (er.last) busy_chk = 1'b1;
          end
        end
      end
    end
  end

  task automatic check_all_zero(input string tag);
    for (int g = 0; g < 2; g++) begin
      check({tag, "_req_ready"}, g, req_ready_w[g], 0);
      check({tag, "_wd_ready"},  g, wd_ready_w[g], 0);
      check({tag, "_rd_valid"},  g, rd_valid_w[g], 0);
      check({tag, "_gb_we"},     g, gb_we_w[g], 0);
      check({tag, "_gb_re"},     g, gb_re_w[g], 0);
      check({tag, "_gb_addr"},   g, gb_addr_w[g], 0);
      check({tag, "_gb_dout"},   g, gb_dout_w[g], 0);
      check({tag, "_busy"},      g, busy_w[g], 0);
    end
  endtask

  task automatic wait_ready();
    int unsigned t = 0;
    while (!(req_ready_w[0] && req_ready_w[1]) && t < 400) begin
      @(posedge clk); #1; t++;
    end
    for (int g = 0; g < 2; g++) check("req_ready_wait", g, req_ready_w[g], 1);
  endtask

  task automatic issue_req(input logic wr, input logic [AW-1:0] addr, input logic [LW-1:0] len);
    wait_ready();
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_len   = len;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_done();
    int unsigned t = 0;
    while (t < 3000 && ((exp_rd[0].size() + exp_rd[1].size() + exp_bus[0].size() + exp_bus[1].size()) != 0
                        || busy_w[0] || busy_w[1])) begin
      @(posedge clk); #1; t++;
    end
    check("drain_complete", 0, exp_rd[0].size() + exp_rd[1].size() + exp_bus[0].size() + exp_bus[1].size(), 0);
    check("idle_after_burst", 0, {busy_w[0], busy_w[1]}, 2'b00);
  endtask

  task automatic do_write(input logic [AW-1:0] addr, input logic [LW-1:0] len, input logic gap,
                          input logic [DW-1:0] d0, input logic [DW-1:0] step);
    issue_req(1'b1, addr, len);
    for (int i = 0; i <= int'(len); i++) begin
      logic [DW-1:0] d;
      logic [AW-1:0] a;
      d = d0 + DW'(i) * step;
      a = addr + AW'(i);
      for (int g = 0; g < 2; g++) begin
        exp_bus[g].push_back('{we: 1'b1, last: (i == int'(len)), addr: a, data: d});
        check("wd_ready_in_write", g, wd_ready_w[g], 1);
      end
      wd_valid = 1'b1;
      wd_data  = d;
      @(posedge clk); #1;
      wd_valid = 1'b0;
      if (gap) begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic do_read(input logic [AW-1:0] addr, input logic [LW-1:0] len);
    for (int i = 0; i <= int'(len); i++) begin
      logic [AW-1:0] a;
      a = addr + AW'(i);
      for (int g = 0; g < 2; g++) begin
        exp_bus[g].push_back('{we: 1'b0, last: 1'b0, addr: a, data: '0});
        exp_rd[g].push_back('{last: (i == int'(len)), data: DW'(a) ^ 32'h0000_A5A5});
      end
    end
    issue_req(1'b0, addr, len);
  endtask

  initial begin
    logic [AW-1:0] wrap_exp [4];
    wrap_exp[0] = 24'hFF_FFFE;
    wrap_exp[1] = 24'hFF_FFFF;
    wrap_exp[2] = 24'h00_0000;
    wrap_exp[3] = 24'h00_0001;

    #1 rst_n = 1'b0;
    #1 check_all_zero("reset");
    #20 rst_n = 1'b1;
    #1 for (int g = 0; g < 2; g++) check("req_ready_before_edge", g, req_ready_w[g], 0);
    @(posedge clk); #1;
    for (int g = 0; g < 2; g++) check("req_ready_after_release", g, req_ready_w[g], 1);
    rd_ready = 1'b1;

    // Single write
    do_write(24'h00_0010, 8'd0, 1'b0, 32'hDEAD_BEEF, 32'h0);
    wait_done();

    // Write burst with stalls, then surplus write beats while idle
    do_write(24'h00_0100, 8'd3, 1'b1, 32'h1111_0000, 32'h0101_0101);
    wait_done();
    wd_valid = 1'b1;
    wd_data  = 32'h5555_5555;
    for (int k = 0; k < 2; k++) begin
      for (int g = 0; g < 2; g++) check("wd_ready_idle", g, wd_ready_w[g], 0);
      @(posedge clk); #1;
    end
    wd_valid = 1'b0;

    // Read burst, no backpressure: eight back-to-back strobes
    do_read(24'h00_0200, 8'd7);
    @(posedge clk);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      for (int g = 0; g < 2; g++) check("gb_re_consecutive", g, gb_re_w[g], 1);
    end
    @(negedge clk);
    for (int g = 0; g < 2; g++) check("gb_re_stops", g, gb_re_w[g], 0);
    @(posedge clk); #1;
    wait_done();

    // Read with rd_ready held low: issue halts at FIFO_DEPTH
    rd_ready = 1'b0;
    re_cnt[0] = 0;
    re_cnt[1] = 0;
    do_read(24'h00_0800, 8'd15);
    repeat (20) @(posedge clk);
    #1;
    check("re_count_stalled", 0, re_cnt[0], 3);
    check("re_count_stalled", 1, re_cnt[1], 5);
    for (int g = 0; g < 2; g++) check("rd_valid_stalled", g, rd_valid_w[g], 1);
    rd_ready = 1'b1;
    wait_done();

    // Address wrap
    re_log[0].delete();
    re_log[1].delete();
    do_read(24'hFF_FFFE, 8'd3);
    wait_done();
    for (int g = 0; g < 2; g++) begin
      check("wrap_count", g, re_log[g].size(), 4);
      for (int k = 0; k < 4; k++)
        if (k < re_log[g].size()) check("wrap_addr", g, re_log[g][k], wrap_exp[k]);
    end

    // Maximum-length write burst (256 beats)
    do_write(24'h00_1000, 8'hFF, 1'b0, 32'hC000_0000, 32'h1);
    wait_done();

    // Reset during the 4th read beat
    do_read(24'h00_0500, 8'd15);
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    for (int g = 0; g < 2; g++) begin
      exp_bus[g].delete();
      exp_rd[g].delete();
    end
    #1 check_all_zero("midreset");
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    #1 for (int g = 0; g < 2; g++) check("req_ready_before_edge2", g, req_ready_w[g], 0);
    @(posedge clk); #1;
    for (int g = 0; g < 2; g++) begin
      check("req_ready_after_midreset", g, req_ready_w[g], 1);
      check("rd_valid_after_midreset", g, rd_valid_w[g], 0);
    end
    do_read(24'h00_0600, 8'd0);
    wait_done();

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion, expected finish before 1ms");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/gb_host_initiator.md
Name: gb_host_initiator

Overview:
- Bus-initiator end of the ghostbus local bus.
- Accepts read/write burst requests on a valid/ready command stream and drives the ghostbus address, data and strobes that the auto-decoded host-accessible registers and RAMs in peripheral modules respond to.
- Streams write data in and read data out with full backpressure.
- Absorbs the bus's fixed read latency with a credit-controlled return buffer.
- Sits between a host-side transport (UART/Ethernet packet engine) and the top-level ghostbus fabric.

Parameters:
- AW, 24, ghostbus address width.
- DW, 32, ghostbus data width.
- RD_LAT, 1, cycles from gb_re asserted to gb_din valid (≥1).
- LW, 8, width of the burst-length field.
- FIFO_DEPTH, RD_LAT+2, read-return buffer depth.

Ports:
- clk  in  1  single clock, also the ghostbus clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  command valid.
- req_ready  out  1  command accepted this cycle when high with req_valid.
- req_write  in  1  1=write burst, 0=read burst.
- req_addr  in  AW  burst base address.
- req_len  in  LW  beats minus one.
- wd_valid  in  1  write-data beat valid.
- wd_ready  out  1  write-data beat accepted.
- wd_data  in  DW  write-data beat.
- rd_valid  out  1  read-data beat valid.
- rd_ready  in  1  read-data beat consumed.
- rd_data  out  DW  read-data beat.
- rd_last  out  1  marks final beat of a read burst.
- busy  out  1  high whenever state≠IDLE.
- gb_addr  out  AW  bus address (registered).
- gb_dout  out  DW  bus write data (registered).
- gb_we  out  1  bus write strobe, one cycle per beat.
- gb_re  out  1  bus read strobe, one cycle per beat.
- gb_din  in  DW  bus read data, valid RD_LAT cycles after gb_re.

Behaviour:
- Reset (asynchronous, active-low):
  - All outputs 0: req_ready=0, wd_ready=0, rd_valid=0, gb_we=0, gb_re=0, gb_addr=0, gb_dout=0.
  - State=IDLE; return FIFO, credit counter and latency pipe cleared.
  - req_ready rises the first cycle after deassertion.
- FSM states: IDLE, WRITE, READ, DRAIN.
- IDLE:
  - req_ready=1.
  - On handshake: latch base=req_addr, remain=req_len, beat=0.
  - Go to WRITE if req_write, else READ.
- WRITE:
  - wd_ready=1 (combinational on state).
  - Each wd handshake registers gb_we=1, gb_addr=base+beat, gb_dout=wd_data next cycle.
  - Cycles without a handshake give gb_we=0.
  - After the (req_len+1)th handshake, go to IDLE; the last gb_we pulse occurs in the first IDLE cycle.
  - Surplus wd beats outside WRITE are not accepted.
- READ:
  - Issue when outstanding+fifo_count < FIFO_DEPTH; registers gb_re=1, gb_addr=base+beat next cycle.
  - outstanding increments on issue and decrements when the RD_LAT delay pipe delivers, pushing gb_din into the FIFO.
  - After the final beat is issued, go to DRAIN.
- DRAIN:
  - Wait until the beat tagged last has been popped (rd_valid & rd_ready & rd_last), then go to IDLE.
- Read return path:
  - FIFO is first-word fall-through; rd_valid=!empty.
  - The last tag travels with the delay pipe.
  - Full throughput: one beat/cycle sustained when rd_ready stays high.
  - Credit check guarantees the FIFO never overflows regardless of rd_ready stalls.
- Address arithmetic: base+beat truncated to AW bits, so bursts wrap from 2^AW−1 to 0.
- Invariants:
  - gb_we and gb_re never high in the same cycle.
  - No new request is accepted until the previous burst fully completes (reads: last beat consumed).
- req_len=0 is a single-beat transfer; req_len=2^LW−1 is 2^LW beats.
- Reset mid-burst: abandon immediately, discard buffered read data, emit no further strobes or responses.

Decomposition:
- Shared package gb_pkg:
  - State encoding enum (IDLE/WRITE/READ/DRAIN).
  - Default AW/DW constants shared with the ghostbus decoder generator.
- One sub-module, gb_rd_fifo:
  - Parameterised FWFT sync FIFO (width DW+1 for data+last, depth FIFO_DEPTH).
  - Count output used for credit accounting.

Test Plan:
- Single write:
  - Stimulus: req write addr=0x000010, len=0, wd 0xDEADBEEF.
  - Response: exactly one gb_we pulse with gb_addr=0x10 and gb_dout=0xDEADBEEF, then req_ready=1.
- Write burst with stalls:
  - Stimulus: len=3, addr=0x100, wd_valid toggled 1/0.
  - Response: four gb_we pulses at 0x100..0x103 carrying data in order; no gb_we on gaps.
- Read burst, no backpressure:
  - Stimulus: RD_LAT=1, len=7, addr=0x200, bus model returns addr^0xA5A5.
  - Response: eight consecutive gb_re cycles; rd_data sequence correct; rd_last only on the 8th beat; busy falls after it.
- Read with rd_ready held low for 20 cycles (RD_LAT=3, len=15):
  - Response: gb_re stops after FIFO_DEPTH outstanding; no data lost; all 16 beats delivered in order once released.
- Wrap:
  - Stimulus: read at addr=0xFFFFFE, len=3.
  - Response: gb_addr sequence FFFFFE, FFFFFF, 000000, 000001.
- Reset mid-read:
  - Stimulus: assert rst_n low during the 4th beat of a len=15 read.
  - Response: all outputs 0 asynchronously; after release, rd_valid=0, req_ready=1, and a new len=0 read returns the correct single beat.
